// File: rtl/symbol_frame_collector_pkg.sv
// Shared decoder types for the symbol front end and branch_metrics_array.
// Holds the soft-value geometry, the frame array typedef and the pad constant.
// Geometry is fixed here so that every block sharing symbol_frame_t agrees on it.
package symbol_frame_collector_pkg;

  localparam int BITS            = 16;  // width of one soft value (opaque)
  localparam int BITS_PER_SYMBOL = 2;   // soft values per symbol
  localparam int SYMBOLS         = 10;  // symbols per frame, at least 2

  localparam int IDX_W = $clog2(SYMBOLS);      // fill index 0..SYMBOLS-1
  localparam int CNT_W = $clog2(SYMBOLS + 1);  // real-symbol count 0..SYMBOLS

  // Pad is all-zero bits: +0.0 in half/single encodings, zero in fixed point.
  localparam logic [BITS-1:0] PAD_VALUE = '0;

  typedef logic [BITS-1:0] symbol_t [BITS_PER_SYMBOL];
  typedef logic [BITS-1:0] symbol_frame_t [SYMBOLS][BITS_PER_SYMBOL];

endpackage

// File: rtl/symbol_frame_collector_if.sv
// Handshake bundle for the symbol collector: symbol input side and frame output side.
// Ports: s_valid/s_ready/s_symbol/s_last (symbol in), out_valid/out_ready/out_symbol/out_count (frame out).
// slave = the collector, master = the producer/consumer pair driving it.
interface symbol_frame_collector_if;
  import symbol_frame_collector_pkg::*;

  logic               s_valid;
  logic               s_ready;
  symbol_t            s_symbol;
  logic               s_last;
  logic               out_valid;
  logic               out_ready;
  symbol_frame_t      out_symbol;
  logic [CNT_W-1:0]   out_count;

  modport slave (
    input  s_valid, s_symbol, s_last, out_ready,
    output s_ready, out_valid, out_symbol, out_count
  );

  modport master (
    output s_valid, s_symbol, s_last, out_ready,
    input  s_ready, out_valid, out_symbol, out_count
  );

endinterface

// File: rtl/symbol_frame_collector.sv
// Purpose: collects SYMBOLS symbols into one parallel frame, zero-padding short (s_last) frames.
// Latency: closing symbol accepted at edge N -> out_valid and frame stable after edge N.
// Backpressure: s_ready drops (FULL) only when a second frame closes while the first is unconsumed.
// Ports: clk, rst (sync, active-high), bus (slave modport of symbol_frame_collector_if).
module symbol_frame_collector
  import symbol_frame_collector_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  symbol_frame_collector_if.slave  bus
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  symbol_frame_t     fill_q;
  symbol_frame_t     out_symbol_q;
  logic [CNT_W-1:0]  out_count_q;
  logic              out_valid_q;

  logic              in_xfer;
  logic              slot_free;
  logic              closing;
  logic              load;
  symbol_frame_t     load_frame;

  // s_ready is a pure decode of the state register: no path from out_ready.
  assign bus.s_ready    = (state_q == FILL);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_symbol = out_symbol_q;
  assign bus.out_count  = out_count_q;

  assign in_xfer   = bus.s_valid && (state_q == FILL);
  assign slot_free = !out_valid_q || bus.out_ready;
  assign closing   = in_xfer && (bus.s_last || (idx_q == IDX_W'(SYMBOLS - 1)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      FILL: begin
        if (in_xfer) begin
          if (closing) begin
            if (slot_free) begin
              load  = 1'b1;
              idx_d = '0;
            end else begin
              // idx stays on the frame's last slot so the deferred load pads correctly
              state_d = FULL;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (slot_free) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Frame presented on a load: slots above idx are padding; in FILL the closing
  // symbol has not reached the buffer yet, so it is bypassed into slot idx.
  always_comb begin
    for (int s = 0; s < SYMBOLS; s++) begin
      for (int b = 0; b < BITS_PER_SYMBOL; b++) begin
        if (IDX_W'(s) > idx_q) begin
          load_frame[s][b] = PAD_VALUE;
        end else if (in_xfer && (IDX_W'(s) == idx_q)) begin
          load_frame[s][b] = bus.s_symbol[b];
        end else begin
          load_frame[s][b] = fill_q[s][b];
        end
      end
    end
  end

  // Fill buffer holds data only; stale contents are always masked by idx on load.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      fill_q[idx_q] <= bus.s_symbol;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_count_q  <= '0;
      out_symbol_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        out_symbol_q <= load_frame;
        out_count_q  <= CNT_W'(idx_q) + CNT_W'(1);
        out_valid_q  <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
